// File: rtl/lif_neuron_bank.sv
// Bank of N leaky integrate-and-fire neurons fed one signed current per cycle.
// Each timestep updates every neuron in index order, then publishes the spike vector.
module lif_neuron_bank #(
  parameter int N          = 256,
  parameter int WIDTH      = 32,
  parameter int LEAK_SHIFT = 4,
  parameter int V_TH       = 1 << 16,
  parameter int V_RESET    = 0,
  parameter int REF_STEPS  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step_start,
  input  logic                    cur_valid,
  output logic                    cur_ready,
  input  logic signed [WIDTH-1:0] cur_data,
  output logic [N-1:0]            spikes,
  output logic                    spikes_valid,
  output logic                    busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int REF_W = (REF_STEPS > 0) ? $clog2(REF_STEPS + 1) : 1;
  localparam int SUM_W = WIDTH + 2;

  localparam logic signed [WIDTH-1:0] VTH_W    = WIDTH'(V_TH);
  localparam logic signed [WIDTH-1:0] VRST_W   = WIDTH'(V_RESET);
  localparam logic [REF_W-1:0]        REF_INIT = REF_W'(REF_STEPS);
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Clamp a WIDTH+2 bit sum into the signed WIDTH range.
  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [SUM_W-1:0] x);
    logic signed [WIDTH-1:0] r;
    if (x[SUM_W-1:WIDTH-1] == {3{x[SUM_W-1]}}) begin
      r = x[WIDTH-1:0];
    end else if (x[SUM_W-1]) begin
      r = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      r = {1'b0, {(WIDTH-1){1'b1}}};
    end
    return r;
  endfunction

  function automatic logic signed [SUM_W-1:0] ext_w(input logic signed [WIDTH-1:0] x);
    logic signed [SUM_W-1:0] r;
    r = {{2{x[WIDTH-1]}}, x};
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [N-1:0]            shadow_q, shadow_d;
  logic [N-1:0]            spikes_q, spikes_d;
  logic signed [WIDTH-1:0] v_q   [N];
  logic [REF_W-1:0]        ref_q [N];

  logic                    xfer;
  logic                    last_xfer;
  logic signed [WIDTH-1:0] v_cur;
  logic signed [WIDTH-1:0] leak;
  logic signed [SUM_W-1:0] sum;
  logic signed [WIDTH-1:0] v_sat;
  logic [REF_W-1:0]        ref_cur;
  logic signed [WIDTH-1:0] v_new_d;
  logic [REF_W-1:0]        ref_new_d;
  logic                    spike_d;

  assign cur_ready    = (state_q == S_RUN);
  assign busy         = (state_q != S_IDLE);
  assign spikes_valid = (state_q == S_DONE);
  assign spikes       = spikes_q;

  assign xfer      = cur_valid && (state_q == S_RUN);
  assign last_xfer = xfer && (idx_q == IDX_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (step_start) begin
          state_d = S_RUN;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Integrate stage: leak, add current, saturate, threshold, refractory.
  always_comb begin
    v_cur     = v_q[idx_q];
    ref_cur   = ref_q[idx_q];
    leak      = v_cur >>> LEAK_SHIFT;
    sum       = ext_w(v_cur) - ext_w(leak) + ext_w(cur_data);
    v_sat     = sat_w(sum);
    v_new_d   = v_sat;
    ref_new_d = ref_cur;
    spike_d   = 1'b0;
    if (ref_cur != '0) begin
      // Refractory neurons discard the incoming current entirely.
      ref_new_d = ref_cur - 1'b1;
      v_new_d   = VRST_W;
    end else if (v_sat >= VTH_W) begin
      spike_d   = 1'b1;
      v_new_d   = VRST_W;
      ref_new_d = REF_INIT;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    spikes_d = spikes_q;
    if (xfer) begin
      shadow_d[idx_q] = spike_d;
    end
    if (last_xfer) begin
      spikes_d = shadow_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      spikes_q <= '0;
      for (int i = 0; i < N; i++) begin
        v_q[i]   <= VRST_W;
        ref_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      spikes_q <= spikes_d;
      if (xfer) begin
        v_q[idx_q]   <= v_new_d;
        ref_q[idx_q] <= ref_new_d;
      end
    end
  end

endmodule
